// File: rtl/m_branch_predictor_pkg.sv
// Shared branch-predictor definitions: counter encodings, default sizes,
// and the pipeline NOP constant used by the stage modules.
package m_branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_cnt_e;

    localparam bp_cnt_e     BP_ALLOC_INIT = BP_WT;
    localparam bp_cnt_e     BP_RST_CNT    = BP_WNT;
    localparam int          BP_IDX_W      = 6;
    localparam int          BP_TAG_W      = 6;
    localparam int          BP_CNT_W      = 32;
    localparam logic [31:0] BP_NOP        = 32'h0000_0013;

endpackage

// File: rtl/m_branch_predictor_sat2.sv
// 2-bit saturating counter next-state: step toward strong-taken on
// a taken outcome, toward strong-not-taken otherwise.
module m_bp_sat2
    import m_branch_predictor_pkg::*;
(
    input  bp_cnt_e i_cnt,
    input  logic    i_inc,
    output bp_cnt_e o_next
);

    // Saturating step; the end states hold.
    always_comb begin
        o_next = i_cnt;
        unique case (i_cnt)
            BP_SNT: if (i_inc) o_next = BP_WNT;
            BP_WNT: if (i_inc) o_next = BP_WT;  else o_next = BP_SNT;
            BP_WT:  if (i_inc) o_next = BP_ST;  else o_next = BP_WNT;
            BP_ST:  if (!i_inc) o_next = BP_WT;
        endcase
    end

endmodule

// File: rtl/m_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters. Lookup is combinational for
// fetch; MEM-stage resolution trains it. Perf counters saturate.
module m_branch_predictor
    import m_branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W,
    parameter int CNT_W = BP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic [31:0]      lu_pc,
    output logic             lu_hit,
    output logic             lu_taken,
    output logic [31:0]      lu_target,
    input  logic             up_valid,
    input  logic [31:0]      up_pc,
    input  logic             up_taken,
    input  logic [31:0]      up_target,
    input  logic             up_mispredict,
    output logic [CNT_W-1:0] perf_lookups,
    output logic [CNT_W-1:0] perf_mispred
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_LO  = IDX_W + 2;
    localparam int TAG_HI  = IDX_W + TAG_W + 1;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    bp_cnt_e          r_cnt    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];

    logic [CNT_W-1:0] r_perf_lookups;
    logic [CNT_W-1:0] r_perf_mispred;

    logic [IDX_W-1:0] w_lu_idx;
    logic [TAG_W-1:0] w_lu_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_accept;
    bp_cnt_e          w_cnt_next;
    logic [CNT_W-1:0] w_cnt_max;
    logic [2*(31-TAG_HI)+3:0] w_unused_pc_bits;

    assign w_lu_idx = lu_pc[TAG_LO-1:2];
    assign w_lu_tag = lu_pc[TAG_HI:TAG_LO];
    assign w_up_idx = up_pc[TAG_LO-1:2];
    assign w_up_tag = up_pc[TAG_HI:TAG_LO];
    assign w_cnt_max = {CNT_W{1'b1}};

    // Byte offset and bits above the tag do not take part in matching.
    assign w_unused_pc_bits = {lu_pc[31:TAG_HI+1], lu_pc[1:0],
                               up_pc[31:TAG_HI+1], up_pc[1:0]};

    // Lookup reads current table contents, so a same-cycle update
    // is only visible on the following cycle.
    always_comb begin
        lu_hit    = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);
        lu_taken  = lu_hit && r_cnt[w_lu_idx][1];
        lu_target = lu_hit ? r_target[w_lu_idx] : 32'd0;
    end

    assign w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_accept = ce && up_valid && !flush;

    m_bp_sat2 u_sat2 (
        .i_cnt  (r_cnt[w_up_idx]),
        .i_inc  (up_taken),
        .o_next (w_cnt_next)
    );

    // Table training: hit adjusts counter, taken miss allocates, flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_cnt[i]    <= BP_RST_CNT;
                r_target[i] <= 32'd0;
            end
        end else if (ce && flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_up_accept) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx] <= w_cnt_next;
                if (up_taken) begin
                    r_target[w_up_idx] <= up_target;
                end
            end else if (up_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_cnt[w_up_idx]    <= BP_ALLOC_INIT;
                r_target[w_up_idx] <= up_target;
            end
        end
    end

    // Saturating performance counters for debug readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_lookups <= '0;
            r_perf_mispred <= '0;
        end else if (ce) begin
            if (lu_hit && (r_perf_lookups != w_cnt_max)) begin
                r_perf_lookups <= r_perf_lookups + 1'b1;
            end
            if (w_up_accept && up_mispredict &&
                (r_perf_mispred != w_cnt_max)) begin
                r_perf_mispred <= r_perf_mispred + 1'b1;
            end
        end
    end

    assign perf_lookups = r_perf_lookups;
    assign perf_mispred = r_perf_mispred;

endmodule
